// File: rtl/vga_fb_arbiter_pkg.sv
// Shared constants and FSM encoding for the VGA frame-buffer arbiter.
// Frame geometry is 640x480 words of 4:4:4 RGB pixels.
package vga_fb_arbiter_pkg;

    localparam int ADDR_W_DEF     = 19;
    localparam int DATA_W_DEF     = 12;
    localparam int FIFO_DEPTH_DEF = 8;

    localparam int H_ACTIVE    = 640;
    localparam int V_ACTIVE    = 480;
    localparam int FRAME_WORDS = H_ACTIVE * V_ACTIVE;

    typedef enum logic [1:0] {
        DISP  = 2'd0,
        TURN  = 2'd1,
        DRAIN = 2'd2
    } arbState_t;

    function automatic int levelWidth(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/fb_wr_fifo.sv
// First-word-fall-through host write FIFO holding {address, data} pairs.
// Ready is registered from the next level, so a full FIFO refuses a push even while popping.
module fb_wr_fifo import vga_fb_arbiter_pkg::*; #(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF,
    parameter int DEPTH  = FIFO_DEPTH_DEF
) (
    input  logic                     iCLK,
    input  logic                     iRST,
    input  logic                     iPush,
    input  logic [ADDR_W-1:0]        iPushAddr,
    input  logic [DATA_W-1:0]        iPushData,
    input  logic                     iPop,
    output logic [ADDR_W-1:0]        oHeadAddr,
    output logic [DATA_W-1:0]        oHeadData,
    output logic [$clog2(DEPTH):0]   oLevel,
    output logic                     oReady
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;

    logic [ADDR_W+DATA_W-1:0] storage [DEPTH];
    logic [PTR_W-1:0]         wrPtr;
    logic [PTR_W-1:0]         rdPtr;
    logic [LVL_W-1:0]         level;
    logic [LVL_W-1:0]         levelNext;
    logic                     readyReg;
    logic                     pushOk;
    logic                     popOk;

    assign pushOk    = iPush & readyReg;
    assign popOk     = iPop & (level != LVL_W'(0));
    assign oHeadAddr = storage[rdPtr][ADDR_W+DATA_W-1:DATA_W];
    assign oHeadData = storage[rdPtr][DATA_W-1:0];
    assign oLevel    = level;
    assign oReady    = readyReg;

    // Occupancy after this cycle's push/pop.
    always_comb begin
        levelNext = level;
        if (pushOk && !popOk) begin
            levelNext = level + LVL_W'(1);
        end else if (popOk && !pushOk) begin
            levelNext = level - LVL_W'(1);
        end else begin
            levelNext = level;
        end
    end

    // Entry storage; contents past the read pointer are don't-care so no reset.
    always_ff @(posedge iCLK) begin
        if (pushOk) begin
            storage[wrPtr] <= {iPushAddr, iPushData};
        end
    end

    // Pointers, level and ready; pointers wrap naturally on the power-of-two depth.
    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            wrPtr    <= '0;
            rdPtr    <= '0;
            level    <= '0;
            readyReg <= 1'b0;
        end else begin
            if (pushOk) begin
                wrPtr <= wrPtr + PTR_W'(1);
            end
            if (popOk) begin
                rdPtr <= rdPtr + PTR_W'(1);
            end
            level    <= levelNext;
            readyReg <= (levelNext < LVL_W'(DEPTH));
        end
    end

endmodule

// File: rtl/vga_fb_arbiter.sv
// Single-port frame-buffer arbiter: the display owns the RAM during active video,
// buffered host writes drain only in blanking after a one-cycle turnaround.
module vga_fb_arbiter import vga_fb_arbiter_pkg::*; #(
    parameter int ADDR_W     = ADDR_W_DEF,
    parameter int DATA_W     = DATA_W_DEF,
    parameter int FIFO_DEPTH = FIFO_DEPTH_DEF
) (
    input  logic                          iCLK,
    input  logic                          iRST,
    input  logic                          iDisp_Active,
    input  logic [ADDR_W-1:0]             iDisp_Addr,
    output logic [DATA_W-1:0]             oDisp_Data,
    output logic                          oDisp_Valid,
    input  logic                          iWr_Req,
    input  logic [ADDR_W-1:0]             iWr_Addr,
    input  logic [DATA_W-1:0]             iWr_Data,
    output logic                          oWr_Ready,
    output logic [ADDR_W-1:0]             oRam_Addr,
    output logic                          oRam_WE,
    output logic [DATA_W-1:0]             oRam_WData,
    input  logic [DATA_W-1:0]             iRam_RData,
    output logic [$clog2(FIFO_DEPTH):0]   oFifo_Level
);

    arbState_t         arbState;
    logic              drainWrite;
    logic [ADDR_W-1:0] headAddr;
    logic [DATA_W-1:0] headData;
    logic              activeDly;
    logic              dispValid;
    logic [DATA_W-1:0] dispData;

    fb_wr_fifo #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .DEPTH  (FIFO_DEPTH)
    ) uWrFifo (
        .iCLK      (iCLK),
        .iRST      (iRST),
        .iPush     (iWr_Req),
        .iPushAddr (iWr_Addr),
        .iPushData (iWr_Data),
        .iPop      (drainWrite),
        .oHeadAddr (headAddr),
        .oHeadData (headData),
        .oLevel    (oFifo_Level),
        .oReady    (oWr_Ready)
    );

    // RAM port mux: kept combinational on iDisp_Active so the display wins the very cycle it returns.
    always_comb begin
        drainWrite = 1'b0;
        oRam_Addr  = iDisp_Addr;
        oRam_WE    = 1'b0;
        oRam_WData = '0;
        if ((arbState == DRAIN) && !iDisp_Active && (oFifo_Level != '0)) begin
            drainWrite = 1'b1;
            oRam_Addr  = headAddr;
            oRam_WE    = 1'b1;
            oRam_WData = headData;
        end else begin
            drainWrite = 1'b0;
        end
    end

    // Ownership FSM.
    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            arbState <= DISP;
        end else begin
            case (arbState)
                DISP:    arbState <= iDisp_Active ? DISP : TURN;
                TURN:    arbState <= iDisp_Active ? DISP : DRAIN;
                DRAIN:   arbState <= iDisp_Active ? DISP : DRAIN;
                default: arbState <= DISP;
            endcase
        end
    end

    // Two-stage read pipeline: RAM latency plus the output register.
    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            activeDly <= 1'b0;
            dispValid <= 1'b0;
            dispData  <= '0;
        end else begin
            activeDly <= iDisp_Active;
            dispValid <= activeDly;
            dispData  <= iRam_RData;
        end
    end

    assign oDisp_Valid = dispValid;
    assign oDisp_Data  = dispData;

endmodule

// File: tb/tb_vga_fb_arbiter.sv
// Directed bench for vga_fb_arbiter with a RAM model and a write-order scoreboard.
module tb_vga_fb_arbiter;
    import vga_fb_arbiter_pkg::*;

    localparam int AW    = 19;
    localparam int DW    = 12;
    localparam int DEPTH = 8;
    localparam int LW    = $clog2(DEPTH) + 1;

    logic          iCLK = 1'b0;
    logic          iRST;
    logic          iDisp_Active;
    logic [AW-1:0] iDisp_Addr;
    logic [DW-1:0] oDisp_Data;
    logic          oDisp_Valid;
    logic          iWr_Req;
    logic [AW-1:0] iWr_Addr;
    logic [DW-1:0] iWr_Data;
    logic          oWr_Ready;
    logic [AW-1:0] oRam_Addr;
    logic          oRam_WE;
    logic [DW-1:0] oRam_WData;
    logic [DW-1:0] iRam_RData;
    logic [LW-1:0] oFifo_Level;

    logic [DW-1:0] ramMem [0:1023];

    int checks   = 0;
    int failures = 0;
    logic [AW+DW-1:0] wrQ [$];

    vga_fb_arbiter #(.ADDR_W(AW), .DATA_W(DW), .FIFO_DEPTH(DEPTH)) dut (
        .iCLK         (iCLK),
        .iRST         (iRST),
        .iDisp_Active (iDisp_Active),
        .iDisp_Addr   (iDisp_Addr),
        .oDisp_Data   (oDisp_Data),
        .oDisp_Valid  (oDisp_Valid),
        .iWr_Req      (iWr_Req),
        .iWr_Addr     (iWr_Addr),
        .iWr_Data     (iWr_Data),
        .oWr_Ready    (oWr_Ready),
        .oRam_Addr    (oRam_Addr),
        .oRam_WE      (oRam_WE),
        .oRam_WData   (oRam_WData),
        .iRam_RData   (iRam_RData),
        .oFifo_Level  (oFifo_Level)
    );

    always #5 iCLK = ~iCLK;

    // Synchronous single-port RAM, read data one cycle after the address.
    always @(posedge iCLK) begin
        if (oRam_WE) begin
            ramMem[oRam_Addr[9:0]] <= oRam_WData;
        end
        iRam_RData <= ramMem[oRam_Addr[9:0]];
    end

    initial begin
        #1000000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Sample point: retire any RAM write against the scoreboard, then record an accepted push.
    task automatic half();
        logic [AW+DW-1:0] e;
        @(negedge iCLK);
        if (oRam_WE) begin
            chk("wr_expected", 32'(wrQ.size() != 0), 32'd1);
            if (wrQ.size() != 0) begin
                e = wrQ.pop_front();
                chk("wr_addr", 32'(oRam_Addr), 32'(e[AW+DW-1:DW]));
                chk("wr_data", 32'(oRam_WData), 32'(e[DW-1:0]));
            end
        end
        if (!iRST && iWr_Req && oWr_Ready) begin
            wrQ.push_back({iWr_Addr, iWr_Data});
        end
    endtask

    task automatic adv();
        @(posedge iCLK);
        #1;
    endtask

    task automatic drainAll(input string tag);
        int n;
        n = 0;
        half();
        while ((oFifo_Level != '0 || oRam_WE) && n < 40) begin
            adv();
            half();
            n++;
        end
        chk(tag, 32'(n < 40), 32'd1);
        chk({tag, "_q_empty"}, 32'(wrQ.size()), 32'd0);
    endtask

    initial begin
        iRST = 1'b1; iDisp_Active = 1'b1; iDisp_Addr = 19'h01234;
        iWr_Req = 1'b0; iWr_Addr = '0; iWr_Data = '0;
        repeat (2) adv();
        half();
        chk("rst_ready", 32'(oWr_Ready), 32'd0);
        chk("rst_we", 32'(oRam_WE), 32'd0);
        chk("rst_wdata", 32'(oRam_WData), 32'd0);
        chk("rst_valid", 32'(oDisp_Valid), 32'd0);
        chk("rst_data", 32'(oDisp_Data), 32'd0);
        chk("rst_level", 32'(oFifo_Level), 32'd0);
        chk("rst_state", 32'(dut.arbState), 32'(DISP));
        adv();
        iRST = 1'b0;
        half();
        chk("ready_before_edge", 32'(oWr_Ready), 32'd0);
        adv(); half();
        chk("ready_after_edge", 32'(oWr_Ready), 32'd1);

        // Three writes buffered during active video.
        for (int i = 0; i < 3; i++) begin
            adv(); iWr_Req = 1'b1; iWr_Addr = AW'(32'h100 + i); iWr_Data = DW'(32'hA00 + i);
            half();
            chk("active_no_we", 32'(oRam_WE), 32'd0);
            chk("active_addr", 32'(oRam_Addr), 32'(iDisp_Addr));
        end
        adv(); iWr_Req = 1'b0; half();
        chk("buf3_level", 32'(oFifo_Level), 32'd3);
        chk("buf3_ready", 32'(oWr_Ready), 32'd1);

        // Blanking: DISP cycle, TURN cycle, then three back-to-back writes.
        adv(); iDisp_Active = 1'b0; half();
        chk("fall_no_we", 32'(oRam_WE), 32'd0);
        adv(); half();
        chk("turn_no_we", 32'(oRam_WE), 32'd0);
        chk("turn_state", 32'(dut.arbState), 32'(TURN));
        for (int i = 0; i < 3; i++) begin
            adv(); half();
            chk("drain_we", 32'(oRam_WE), 32'd1);
            chk("drain_level", 32'(oFifo_Level), 32'(3 - i));
        end
        adv(); iDisp_Addr = 19'h05555; half();
        chk("idle_we", 32'(oRam_WE), 32'd0);
        chk("idle_level", 32'(oFifo_Level), 32'd0);
        chk("idle_addr", 32'(oRam_Addr), 32'h05555);

        // Write 0xABC to 0x04B during blanking, then read it back.
        adv(); iWr_Req = 1'b1; iWr_Addr = 19'h0004B; iWr_Data = 12'hABC; half();
        adv(); iWr_Req = 1'b0; half();
        chk("abc_we", 32'(oRam_WE), 32'd1);
        adv(); iDisp_Active = 1'b1; iDisp_Addr = 19'h0004B; half();
        chk("rise_no_we", 32'(oRam_WE), 32'd0);
        chk("rise_addr", 32'(oRam_Addr), 32'h0004B);
        adv(); iDisp_Addr = 19'h00100; half();
        chk("rd_valid_lat1", 32'(oDisp_Valid), 32'd0);
        adv(); half();
        chk("rd_valid_lat2", 32'(oDisp_Valid), 32'd1);
        chk("rd_data_abc", 32'(oDisp_Data), 32'hABC);
        adv(); half();
        chk("rd_data_a00", 32'(oDisp_Data), 32'hA00);

        // Fill the FIFO, hold a ninth request until a pop frees a slot.
        for (int i = 0; i < 8; i++) begin
            adv(); iWr_Req = 1'b1; iWr_Addr = AW'(32'h200 + i); iWr_Data = DW'(32'h300 + i);
            half();
            chk("fill_no_we", 32'(oRam_WE), 32'd0);
        end
        adv(); iWr_Addr = 19'h00208; iWr_Data = 12'h308; half();
        chk("full_level", 32'(oFifo_Level), 32'd8);
        chk("full_ready", 32'(oWr_Ready), 32'd0);
        for (int i = 0; i < 2; i++) begin
            adv(); half();
            chk("full_hold", 32'(oFifo_Level), 32'd8);
        end
        adv(); iDisp_Active = 1'b0; half();
        chk("full_fall_we", 32'(oRam_WE), 32'd0);
        adv(); half();
        chk("full_turn_we", 32'(oRam_WE), 32'd0);
        adv(); half();
        chk("full_pop_we", 32'(oRam_WE), 32'd1);
        chk("full_pop_ready", 32'(oWr_Ready), 32'd0);
        adv(); half();
        chk("slot_free_ready", 32'(oWr_Ready), 32'd1);
        chk("slot_free_level", 32'(oFifo_Level), 32'd7);
        adv(); iWr_Req = 1'b0;
        drainAll("full_drain");

        // Display interrupts a drain after the first write.
        adv(); iDisp_Active = 1'b1; half();
        for (int i = 0; i < 4; i++) begin
            adv(); iWr_Req = 1'b1; iWr_Addr = AW'(32'h400 + i); iWr_Data = DW'(32'h500 + i);
            half();
        end
        adv(); iWr_Req = 1'b0; iDisp_Active = 1'b0; half();
        adv(); half();
        adv(); half();
        chk("intr_first_we", 32'(oRam_WE), 32'd1);
        adv(); iDisp_Active = 1'b1; iDisp_Addr = 19'h00777; half();
        chk("intr_stop_we", 32'(oRam_WE), 32'd0);
        chk("intr_stop_addr", 32'(oRam_Addr), 32'h00777);
        chk("intr_level", 32'(oFifo_Level), 32'd3);
        adv(); half();
        chk("intr_hold_level", 32'(oFifo_Level), 32'd3);
        adv(); iDisp_Active = 1'b0;
        drainAll("intr_resume");

        // Reset in the middle of a drain.
        adv(); iDisp_Active = 1'b1; half();
        for (int i = 0; i < 6; i++) begin
            adv(); iWr_Req = 1'b1; iWr_Addr = AW'(32'h600 + i); iWr_Data = DW'(32'h700 + i);
            half();
        end
        adv(); iWr_Req = 1'b0; iDisp_Active = 1'b0; half();
        adv(); half();
        adv(); half();
        adv(); half();
        chk("mid_level5", 32'(oFifo_Level), 32'd5);
        chk("mid_we", 32'(oRam_WE), 32'd1);
        #1 iRST = 1'b1;
        #1;
        chk("async_we", 32'(oRam_WE), 32'd0);
        chk("async_level", 32'(oFifo_Level), 32'd0);
        chk("async_ready", 32'(oWr_Ready), 32'd0);
        chk("async_wdata", 32'(oRam_WData), 32'd0);
        chk("async_state", 32'(dut.arbState), 32'(DISP));
        wrQ.delete();
        adv(); adv();
        iRST = 1'b0;
        for (int i = 0; i < 6; i++) begin
            half();
            chk("post_rst_no_we", 32'(oRam_WE), 32'd0);
            chk("post_rst_level", 32'(oFifo_Level), 32'd0);
            adv();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/vga_fb_arbiter.md
VGA_FB_ARBITER -- requirements
Module: vga_fb_arbiter

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 19, the frame-buffer word address width (640x480 = 307200 words).
REQ-002 The block SHALL have parameter DATA_W, default 12, the pixel width (4R:4G:4B).
REQ-003 The block SHALL have parameter FIFO_DEPTH, default 8, the write FIFO depth, a power of two and at least 2.
REQ-004 Port iCLK, input, width 1: the single pixel clock; all state SHALL update on its rising edge.
REQ-005 Port iRST, input, width 1: reset, asynchronous and active-high.
REQ-006 Port iDisp_Active, input, width 1: the display owns the RAM this cycle (active video region).
REQ-007 Port iDisp_Addr, input, width ADDR_W: display read address.
REQ-008 Port oDisp_Data, output, width DATA_W: pixel returned to the display.
REQ-009 Port oDisp_Valid, output, width 1: oDisp_Data is valid.
REQ-010 Port iWr_Req, input, width 1: host write valid.
REQ-011 Port iWr_Addr, input, width ADDR_W: host write address.
REQ-012 Port iWr_Data, input, width DATA_W: host write data.
REQ-013 Port oWr_Ready, output, width 1: the FIFO can accept a write.
REQ-014 Port oRam_Addr, output, width ADDR_W: single-port RAM address.
REQ-015 Port oRam_WE, output, width 1: RAM write enable.
REQ-016 Port oRam_WData, output, width DATA_W: RAM write data.
REQ-017 Port iRam_RData, input, width DATA_W: RAM read data, available 1 cycle after the address.
REQ-018 Port oFifo_Level, output, width clog2(FIFO_DEPTH)+1: current FIFO occupancy.

Function
REQ-019 Host writes SHALL use a valid/ready handshake: a write is accepted in any cycle with iWr_Req=1 and oWr_Ready=1.
REQ-020 oWr_Ready SHALL equal (level < FIFO_DEPTH) and SHALL depend only on registered state.
REQ-021 A push into a full FIFO SHALL NOT be accepted, even when a pop occurs in the same cycle.
REQ-022 The FSM SHALL have three states: DISP, TURN and DRAIN.
REQ-023 In DISP, the RAM SHALL be driven by the display: oRam_Addr=iDisp_Addr, oRam_WE=0.
REQ-024 In DISP, the FSM SHALL move to TURN when iDisp_Active=0.
REQ-025 TURN SHALL last one cycle with oRam_WE=0, then go to DRAIN, or to DISP if iDisp_Active=1.
REQ-026 In DRAIN with iDisp_Active=0 and level>0, the FSM SHALL pop one entry per cycle: oRam_WE=1, oRam_Addr/oRam_WData = FIFO head.
REQ-027 From DRAIN, when iDisp_Active=1 the FSM SHALL go to DISP in the same cycle; the RAM mux SHALL be combinational on iDisp_Active, so no write is issued and no entry is popped that cycle.
REQ-028 The display SHALL never be stalled, and a display read SHALL take priority over every write.
REQ-029 Read latency SHALL be 2 cycles: oDisp_Data is iRam_RData registered, and oDisp_Valid is iDisp_Active delayed 2 cycles.
REQ-030 Simultaneous push and pop on a non-full FIFO SHALL leave the level unchanged.
REQ-031 FIFO pointers SHALL wrap modulo FIFO_DEPTH.
REQ-032 Writes SHALL be performed in acceptance order.
REQ-033 When idle (DRAIN with level=0), the block SHALL drive oRam_Addr=iDisp_Addr and oRam_WE=0.

Reset
REQ-034 While iRST=1, the block SHALL set: FSM=DISP, level=0, pointers=0, oDisp_Data=0, oDisp_Valid=0, oRam_WE=0, oRam_WData=0, oWr_Ready=0.
REQ-035 Writes held in the FIFO when reset asserts SHALL be discarded, and oRam_WE SHALL fall asynchronously.
REQ-036 oWr_Ready SHALL become 1 on the first iCLK edge after iRST deasserts.

Structure
REQ-037 A shared package SHALL hold ADDR_W, DATA_W, FIFO_DEPTH defaults, the 640x480 frame constants and the FSM state encoding (DISP=2'd0, TURN=2'd1, DRAIN=2'd2).
REQ-038 The write FIFO SHALL be a separate sub-module, fb_wr_fifo (synchronous, first-word-fall-through, level output); the arbiter FSM and the read pipeline stay in vga_fb_arbiter.

Verification
REQ-039 Scenario: with iDisp_Active=1, push 3 writes (addr 0x100..0x102) -> oRam_WE stays 0, level=3, oWr_Ready=1.
REQ-040 Scenario: iDisp_Active falls with level=3 -> 1 TURN cycle, then writes to 0x100, 0x101, 0x102 on 3 consecutive cycles, level=0.
REQ-041 Scenario: push 8 writes during active video -> oWr_Ready=0 after the 8th, and a 9th iWr_Req is held (not accepted) until a pop frees a slot.
REQ-042 Scenario: iDisp_Active rises after the 1st of 4 drain writes -> writes stop that cycle, level=3, and the remaining writes resume at the next blanking in order.
REQ-043 Scenario: iDisp_Addr=0x0004B with RAM word 0xABC -> oDisp_Data=0xABC and oDisp_Valid=1 exactly 2 cycles later.
REQ-044 Scenario: assert iRST mid-drain with level=5 -> oRam_WE=0 immediately, level=0, FSM=DISP, and no stale writes after release.
